cmac_packet_filter_fifo: RTL and testbench

Single-clock, parametrised AXI-Stream packet FIFO for the CMAC clock domain, the next generation of the fixed 512-bit TX packetisation stage. It only releases a packet downstream once its final beat has been written, so the CMAC never sees an underrun mid-frame. Unlike the previous stage it can discard packets flagged bad on `tuser` at `tlast`, discards packets too large to ever fit, and exposes drop counters and occupancy. It sits between the user-to-CMAC CDC FIFO and the CMAC TX port, one instance per channel.

---
 rtl/cmac_packet_filter_fifo_pkg.sv | 9 +
 rtl/cmac_packet_filter_fifo_sdp_ram.sv | 20 ++
 rtl/cmac_packet_filter_fifo.sv | 110 +++++++++++
 tb/tb_cmac_packet_filter_fifo.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmac_packet_filter_fifo_pkg.sv
// cmac_packet_filter_fifo_pkg: write-FSM encodings and RAM word sizing shared by the FIFO files
package cmac_packet_filter_fifo_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCEPT  = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;
  function automatic int beat_w(input int dw);
    return dw + dw / 8 + 2;
  endfunction
endpackage

// File: rtl/cmac_packet_filter_fifo_sdp_ram.sv
// cmac_packet_filter_fifo_sdp_ram: simple dual-port RAM, one write port and one registered read port
module cmac_packet_filter_fifo_sdp_ram #(
  parameter int W = 8,
  parameter int D = 16,
  localparam int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [D];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/cmac_packet_filter_fifo.sv
// cmac_packet_filter_fifo: AXI-Stream packet FIFO that releases only complete packets, dropping
// tuser-errored and oversize packets, with a 2-entry output skid buffer behind a sync-read RAM
module cmac_packet_filter_fifo
  import cmac_packet_filter_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 512,
  parameter int DEPTH         = 256,
  parameter int DROP_ON_ERROR = 1,
  localparam int KW = DATA_WIDTH / 8,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1,
  localparam int BW = beat_w(DATA_WIDTH)
) (
  input  logic                  cmac_clk,
  input  logic                  cmac_resetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KW-1:0]         s_axis_tkeep,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KW-1:0]         m_axis_tkeep,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [31:0]           drop_err_count,
  output logic [31:0]           drop_oversize_count,
  output logic [PW-1:0]         occupancy
);
  logic [PW-1:0] r_rd_ptr, r_wr_ptr, r_wr_tmp, r_raddr;
  logic [1:0]    r_state, r_cnt, w_lvl;
  logic          r_pend, r_rdy_en;
  logic [BW-1:0] r_buf0, r_buf1, w_rdata;
  logic [31:0]   r_err_cnt, r_ovs_cnt;
  logic          w_full, w_ovf, w_acc, w_we, w_bad, w_pop, w_re;
  // r_rd_ptr only moves when a beat leaves the skid buffer, so full/occupancy count the output stage
  assign w_full = (r_wr_tmp - r_rd_ptr) == PW'(DEPTH);
  assign w_ovf  = w_full && (r_wr_ptr == r_rd_ptr) && r_state != ST_DISCARD;
  assign s_axis_tready = r_rdy_en && (r_state == ST_DISCARD || !w_full || w_ovf);
  assign w_acc  = s_axis_tvalid && s_axis_tready;
  assign w_we   = w_acc && r_state != ST_DISCARD && !w_ovf;
  assign w_bad  = s_axis_tlast && s_axis_tuser && DROP_ON_ERROR != 0;
  assign w_pop  = r_cnt != 2'd0 && m_axis_tready;
  assign w_lvl  = r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
  assign w_re   = r_raddr != r_wr_ptr && w_lvl < 2'd2;
  assign m_axis_tvalid = r_cnt != 2'd0;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = r_buf0;
  assign drop_err_count      = r_err_cnt;
  assign drop_oversize_count = r_ovs_cnt;
  assign occupancy           = r_wr_ptr - r_rd_ptr;
  cmac_packet_filter_fifo_sdp_ram #(.W(BW), .D(DEPTH)) u_ram (
    .clk     (cmac_clk),
    .i_we    (w_we),
    .i_waddr (r_wr_tmp[AW-1:0]),
    .i_wdata ({s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast}),
    .i_re    (w_re),
    .i_raddr (r_raddr[AW-1:0]),
    .o_rdata (w_rdata)
  );
  always_ff @(posedge cmac_clk or negedge cmac_resetn) begin
    if (!cmac_resetn) begin
      r_state   <= ST_IDLE;
      r_wr_ptr  <= '0;
      r_wr_tmp  <= '0;
      r_err_cnt <= '0;
      r_ovs_cnt <= '0;
      r_rdy_en  <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_acc) begin
        if (r_state == ST_DISCARD) begin
          r_state <= s_axis_tlast ? ST_IDLE : ST_DISCARD;
        end else if (w_ovf) begin
          r_wr_tmp  <= r_wr_ptr;
          r_ovs_cnt <= r_ovs_cnt + 32'd1;
          r_state   <= s_axis_tlast ? ST_IDLE : ST_DISCARD;
        end else if (w_bad) begin
          r_wr_tmp  <= r_wr_ptr;
          r_err_cnt <= r_err_cnt + 32'd1;
          r_state   <= ST_IDLE;
        end else begin
          r_wr_tmp <= r_wr_tmp + 1'b1;
          if (s_axis_tlast) r_wr_ptr <= r_wr_tmp + 1'b1;
          r_state <= s_axis_tlast ? ST_IDLE : ST_ACCEPT;
        end
      end
    end
  end
  // r_pend marks a RAM word arriving this cycle; the issue rule keeps skid plus in-flight at most 2
  always_ff @(posedge cmac_clk or negedge cmac_resetn) begin
    if (!cmac_resetn) begin
      r_rd_ptr <= '0;
      r_raddr  <= '0;
      r_pend   <= 1'b0;
      r_cnt    <= 2'd0;
      r_buf0   <= '0;
      r_buf1   <= '0;
    end else begin
      r_pend <= w_re;
      r_cnt  <= w_lvl;
      if (w_re) r_raddr <= r_raddr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (r_pend && (r_cnt == 2'd0 || (w_pop && r_cnt == 2'd1))) r_buf0 <= w_rdata;
      else if (w_pop && r_cnt == 2'd2) r_buf0 <= r_buf1;
      if (r_pend && ((r_cnt == 2'd1 && !w_pop) || (r_cnt == 2'd2 && w_pop))) r_buf1 <= w_rdata;
    end
  end
endmodule

// File: tb/tb_cmac_packet_filter_fifo.sv
// tb_cmac_packet_filter_fifo: directed and random packet traffic checked against a packet-level
// scoreboard, with hand-computed literals for latency, drops, backpressure and reset
module tb_cmac_packet_filter_fifo;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int D  = 16;
  localparam int PW = 5;
  typedef struct packed {logic [DW-1:0] d; logic [KW-1:0] k; logic u; logic l;} beat_t;
  logic clk = 0, rstn = 0;
  logic [DW-1:0] s_data = '0;
  logic [KW-1:0] s_keep = '0;
  logic s_user = 0, s_last = 0, s_valid = 0, b_valid = 0, m_ready = 1;
  logic s_ready, m_valid, m_user, m_last, b_ready, b_m_valid, b_m_user, b_m_last;
  logic [DW-1:0] m_data, b_m_data;
  logic [KW-1:0] m_keep, b_m_keep;
  logic [31:0] err_cnt, ovs_cnt, b_err_cnt, b_ovs_cnt;
  logic [PW-1:0] occ, b_occ;
  beat_t pkt_q[$], exp_q[$], bq[$];
  beat_t prev;
  int occ_m, err_m, ovs_m, n_out, s_acc, n_chk, n_pass, occ_max, cyc, first_v, last_cyc, max_stall;
  bit disc, prev_stall, rnd_ready, b_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cmac_packet_filter_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .DROP_ON_ERROR(1)) u_dut (
    .cmac_clk(clk), .cmac_resetn(rstn),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tuser(s_user), .s_axis_tlast(s_last),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tuser(m_user), .m_axis_tlast(m_last),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .drop_err_count(err_cnt), .drop_oversize_count(ovs_cnt), .occupancy(occ));

  cmac_packet_filter_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .DROP_ON_ERROR(0)) u_dut_fwd (
    .cmac_clk(clk), .cmac_resetn(rstn),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tuser(s_user), .s_axis_tlast(s_last),
    .s_axis_tvalid(b_valid), .s_axis_tready(b_ready),
    .m_axis_tdata(b_m_data), .m_axis_tkeep(b_m_keep), .m_axis_tuser(b_m_user), .m_axis_tlast(b_m_last),
    .m_axis_tvalid(b_m_valid), .m_axis_tready(1'b1),
    .drop_err_count(b_err_cnt), .drop_oversize_count(b_ovs_cnt), .occupancy(b_occ));

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Packet-level model: a packet is released whole at tlast unless errored or longer than D beats
  always @(negedge clk) begin
    if (!rstn) begin
      chk("reset_outputs", |{s_ready, m_valid, m_data, m_keep, m_user, m_last, occ, err_cnt, ovs_cnt}, 0);
      pkt_q.delete(); exp_q.delete();
      occ_m = 0; err_m = 0; ovs_m = 0; disc = 0; prev_stall = 0;
    end else begin
      chk("occupancy", occ, occ_m);
      chk("drop_err_count", err_cnt, err_m);
      chk("drop_oversize_count", ovs_cnt, ovs_m);
      if (occ > occ_max) occ_max = occ;
      if (m_valid && first_v < 0) first_v = cyc;
      if (prev_stall) chk("axi_hold", {m_valid, m_data, m_keep, m_user, m_last} == {1'b1, prev}, 1);
      prev_stall = m_valid && !m_ready;
      prev = {m_data, m_keep, m_user, m_last};
      if (s_valid && s_ready) begin
        s_acc++;
        if (disc) begin
          if (s_last) disc = 0;
        end else begin
          pkt_q.push_back({s_data, s_keep, s_user, s_last});
          if (pkt_q.size() == D + 1) begin
            ovs_m++; pkt_q.delete(); disc = !s_last;
          end else if (s_last) begin
            if (s_user) err_m++;
            else begin
              foreach (pkt_q[i]) exp_q.push_back(pkt_q[i]);
              occ_m += pkt_q.size();
            end
            pkt_q.delete();
          end
        end
      end
      if (m_valid && m_ready) begin
        n_out++;
        if (exp_q.size() == 0) chk("unexpected_beat", m_data, -1);
        else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("out_data", m_data, e.d);
          chk("out_ctl", {m_keep, m_user, m_last}, {e.k, e.u, e.l});
          occ_m--;
        end
      end
    end
  end

  always @(negedge clk) if (rstn && b_m_valid) bq.push_back({b_m_data, b_m_keep, b_m_user, b_m_last});

  initial forever begin
    @(posedge clk); #1;
    if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input bit sel, input int len, input bit bad, input int gap, input int id);
    for (int i = 0; i < len; i++) begin
      int t;
      bit hs;
      while (gap != 0 && $urandom_range(0, gap) == 0) begin
        s_valid = 0; b_valid = 0; idle(1);
      end
      s_data = {id[15:0], i[15:0]};
      s_keep = KW'($urandom);
      s_last = i == len - 1;
      s_user = s_last && bad;
      if (sel) b_valid = 1; else s_valid = 1;
      t = 0;
      do begin
        @(negedge clk); hs = sel ? b_ready : s_ready;
        @(posedge clk); #1; t++;
      end while (!hs && t < 2000);
      if (!hs) begin chk("send_timeout", t, -1); break; end
      if (t - 1 > max_stall) max_stall = t - 1;
    end
    s_valid = 0; b_valid = 0;
    last_cyc = cyc;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || m_valid) && t < 1000) begin idle(1); t++; end
    chk("drain_in_time", t < 1000, 1);
  endtask

  initial begin
    int n0, a0;
    first_v = -1;
    repeat (3) @(posedge clk);
    #2 rstn = 1;
    @(posedge clk); #1;
    chk("tready_after_reset", s_ready, 1);
    // 4-beat packet: tvalid first high two edges after the tlast edge
    first_v = -1;
    send(0, 4, 0, 0, 1);
    idle(10);
    chk("commit_latency", first_v - last_cyc, 2);
    wait_drain();
    chk("occ_after_drain", occ, 0);
    chk("beats_out_pkt1", n_out, 4);
    // errored packet is swallowed; the next good one passes
    n0 = n_out;
    send(0, 3, 1, 0, 2);
    idle(10);
    chk("err_count_literal", err_cnt, 1);
    chk("err_no_output", n_out - n0, 0);
    send(0, 5, 0, 0, 3);
    wait_drain();
    chk("good_after_err", n_out - n0, 5);
    // DROP_ON_ERROR=0 instance forwards the errored packet with tuser set
    send(1, 3, 1, 0, 4);
    idle(10);
    chk("fwd_len", bq.size(), 3);
    if (bq.size() == 3) begin
      chk("fwd_first_data", bq[0].d, 32'h0004_0000);
      chk("fwd_last_data", bq[2].d, 32'h0004_0002);
      chk("fwd_last_user", {bq[2].u, bq[2].l}, 2'b11);
    end
    chk("fwd_err_count", b_err_cnt, 0);
    // 20-beat packet into empty DEPTH=16: beat 17 drops, rest swallowed without stall
    n0 = n_out; max_stall = 0;
    send(0, 20, 0, 0, 5);
    idle(10);
    chk("oversize_literal", ovs_cnt, 1);
    chk("oversize_no_stall", max_stall, 0);
    chk("oversize_no_output", n_out - n0, 0);
    chk("oversize_occ", occ, 0);
    // backpressure: A committed and held, B stalls after its 6th beat
    n0 = n_out;
    m_ready = 0;
    send(0, 10, 0, 0, 6);
    a0 = s_acc; b_done = 0;
    fork begin send(0, 10, 0, 0, 7); b_done = 1; end join_none
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (s_valid && !s_ready) break;
    end
    chk("b_beats_before_stall", s_acc - a0, 6);
    chk("occ_at_stall", occ, 10);
    idle(5);
    chk("stall_held", s_acc - a0, 6);
    m_ready = 1;
    for (int t = 0; t < 200 && !b_done; t++) idle(1);
    chk("b_completed", b_done, 1);
    wait_drain();
    chk("ab_beats_out", n_out - n0, 20);
    // random traffic
    occ_max = 0; rnd_ready = 1;
    for (int p = 0; p < 100; p++)
      send(0, $urandom_range(1, 12), $urandom_range(0, 7) == 0, 2, 100 + p);
    rnd_ready = 0; m_ready = 1;
    wait_drain();
    chk("occ_max_le_depth", occ_max <= D, 1);
    // reset with a packet mid-read and another mid-write
    m_ready = 0;
    send(0, 8, 0, 0, 300);
    m_ready = 1;
    s_data = 32'hdead_0000; s_keep = 4'hf; s_last = 0; s_user = 0; s_valid = 1;
    repeat (3) @(posedge clk);
    #2 rstn = 0; s_valid = 0;
    #1 chk("reset_async_tvalid", m_valid, 0);
    chk("reset_async_occ", occ, 0);
    idle(2);
    #2 rstn = 1;
    @(posedge clk); #1;
    chk("tready_after_rerelease", s_ready, 1);
    n0 = n_out;
    send(0, 3, 0, 0, 301);
    wait_drain();
    chk("post_reset_beats", n_out - n0, 3);
    chk("post_reset_occ", occ, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end
endmodule
